// File: rtl/rv_pkg.sv
// Shared types and sizing for the writeback stage and register file.
package rv_pkg;
   localparam int XLEN   = 64;
   localparam int REG_AW = 5;
   localparam int NREGS  = 2 ** REG_AW;
   localparam int CNT_W  = 64;

   typedef logic [XLEN-1:0]   xword_t;
   typedef logic [REG_AW-1:0] regaddr_t;
   typedef logic [CNT_W-1:0]  wcount_t;

   localparam regaddr_t ZERO_REG = '0;
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-side and ID-side signals of the writeback stage, bundled.
interface wb_regfile_if;
   import rv_pkg::*;

   xword_t   readdata;
   xword_t   result_alu_out;
   regaddr_t rd;
   logic     Memtoreg;
   logic     Regwrite;
   regaddr_t rs1;
   regaddr_t rs2;
   xword_t   rd1;
   xword_t   rd2;
   xword_t   wb_data;
   logic     wb_en;
   wcount_t  wr_count;

   modport master (
      output readdata, result_alu_out, rd, Memtoreg, Regwrite, rs1, rs2,
      input  rd1, rd2, wb_data, wb_en, wr_count
   );

   modport slave (
      input  readdata, result_alu_out, rd, Memtoreg, Regwrite, rs1, rs2,
      output rd1, rd2, wb_data, wb_en, wr_count
   );
endinterface

// File: rtl/wb_regfile_regfile_2r1w.sv
// 32-entry integer register file: one write port, two raw read ports, x0 hardwired to zero.
module regfile_2r1w
   import rv_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     we,
   input  regaddr_t wa,
   input  xword_t   wd,
   input  regaddr_t ra1,
   input  regaddr_t ra2,
   output xword_t   rd1,
   output xword_t   rd2
);

   xword_t regs_q [NREGS];
   xword_t regs_d [NREGS];

   // Next-state of the array: only the addressed non-zero entry changes.
   always_comb begin
      regs_d = regs_q;
      if (we && (wa != ZERO_REG)) begin
         regs_d[wa] = wd;
      end
   end

   // Storage flops; reset clears every entry immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Raw reads; x0 is masked here so it never depends on array contents.
   always_comb begin
      rd1 = (ra1 == ZERO_REG) ? '0 : regs_q[ra1];
      rd2 = (ra2 == ZERO_REG) ? '0 : regs_q[ra2];
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, commit into the register file, ID read ports
// with same-cycle write-through, and a committed-write counter.
module wb_regfile
   import rv_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   wb_regfile_if.slave   bus
);

   xword_t  wb_data;
   logic    wb_en;
   xword_t  raw_rd1;
   xword_t  raw_rd2;
   wcount_t wr_count_q;
   wcount_t wr_count_d;

   // Writeback select and effective write enable (x0 writes are dropped).
   always_comb begin
      wb_data = bus.Memtoreg ? bus.readdata : bus.result_alu_out;
      wb_en   = bus.Regwrite && (bus.rd != ZERO_REG);
   end

   regfile_2r1w u_rf (
      .clk   (clk),
      .reset (reset),
      .we    (wb_en),
      .wa    (bus.rd),
      .wd    (wb_data),
      .ra1   (bus.rs1),
      .ra2   (bus.rs2),
      .rd1   (raw_rd1),
      .rd2   (raw_rd2)
   );

   // Read ports: x0 reads zero, a matching in-flight write wins over storage.
   always_comb begin
      if (bus.rs1 == ZERO_REG) begin
         bus.rd1 = '0;
      end else if (wb_en && (bus.rs1 == bus.rd)) begin
         bus.rd1 = wb_data;
      end else begin
         bus.rd1 = raw_rd1;
      end

      if (bus.rs2 == ZERO_REG) begin
         bus.rd2 = '0;
      end else if (wb_en && (bus.rs2 == bus.rd)) begin
         bus.rd2 = wb_data;
      end else begin
         bus.rd2 = raw_rd2;
      end
   end

   // Counter next-state; wraps silently at all-ones.
   always_comb begin
      wr_count_d = wr_count_q;
      if (wb_en) begin
         wr_count_d = wr_count_q + wcount_t'(1);
      end
   end

   // Committed-write counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_count_q <= '0;
      end else begin
         wr_count_q <= wr_count_d;
      end
   end

   assign bus.wb_data  = wb_data;
   assign bus.wb_en    = wb_en;
   assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table plus reset, async-reset and counter-wrap sequences.
module tb_wb_regfile;
   import rv_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   wb_regfile_if bus ();

   wb_regfile dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic     regwrite;
      logic     memtoreg;
      regaddr_t rd;
      xword_t   readdata;
      xword_t   alu;
      regaddr_t rs1;
      regaddr_t rs2;
      xword_t   exp_rd1;
      xword_t   exp_rd2;
      xword_t   exp_wb_data;
      logic     exp_wb_en;
      wcount_t  exp_count;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rw, input logic m2r, input regaddr_t rd,
                        input xword_t rdata, input xword_t alu,
                        input regaddr_t rs1, input regaddr_t rs2);
      bus.Regwrite       = rw;
      bus.Memtoreg       = m2r;
      bus.rd             = rd;
      bus.readdata       = rdata;
      bus.result_alu_out = alu;
      bus.rs1            = rs1;
      bus.rs2            = rs2;
   endtask

   // Advance to just after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      //            rw m2r rd  readdata               alu      rs1 rs2 exp_rd1  exp_rd2  exp_wb                 en cnt
      vecs[0]  = '{1'b1, 1'b0, 5'd5,  64'hDEAD,              64'h1234, 5'd5,  5'd0,  64'h1234, 64'h0,    64'h1234,              1'b1, 64'd0};
      vecs[1]  = '{1'b0, 1'b0, 5'd5,  64'h0,                 64'h0,    5'd0,  5'd5,  64'h0,    64'h1234, 64'h0,                 1'b0, 64'd1};
      vecs[2]  = '{1'b1, 1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0,  5'd0,  5'd0,  64'h0,    64'h0,    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd1};
      vecs[3]  = '{1'b0, 1'b0, 5'd0,  64'h0,                 64'h0,    5'd0,  5'd5,  64'h0,    64'h1234, 64'h0,                 1'b0, 64'd1};
      vecs[4]  = '{1'b1, 1'b0, 5'd7,  64'h0,                 64'hA,    5'd7,  5'd7,  64'hA,    64'hA,    64'hA,                 1'b1, 64'd1};
      vecs[5]  = '{1'b1, 1'b0, 5'd7,  64'h0,                 64'hB,    5'd7,  5'd7,  64'hB,    64'hB,    64'hB,                 1'b1, 64'd2};
      vecs[6]  = '{1'b0, 1'b0, 5'd7,  64'h0,                 64'h0,    5'd7,  5'd7,  64'hB,    64'hB,    64'h0,                 1'b0, 64'd3};
      vecs[7]  = '{1'b1, 1'b1, 5'd31, 64'h31,                64'h99,   5'd31, 5'd5,  64'h31,   64'h1234, 64'h31,                1'b1, 64'd3};
      vecs[8]  = '{1'b0, 1'b1, 5'd31, 64'h77,                64'h0,    5'd31, 5'd7,  64'h31,   64'hB,    64'h77,                1'b0, 64'd4};
      vecs[9]  = '{1'b1, 1'b0, 5'd1,  64'h0,                 64'h1,    5'd2,  5'd1,  64'h0,    64'h1,    64'h1,                 1'b1, 64'd4};
      vecs[10] = '{1'b0, 1'b0, 5'd0,  64'h0,                 64'h0,    5'd1,  5'd31, 64'h1,    64'h31,   64'h0,                 1'b0, 64'd5};

      reset = 1'b1;
      drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd0, 5'd0);
      #12;
      reset = 1'b0;
      next_cycle();

      // Reset state: every address reads zero on both ports.
      chk("reset_wr_count", bus.wr_count, 64'd0);
      for (int i = 0; i < NREGS; i++) begin
         drive(1'b0, 1'b0, 5'd0, '0, '0, regaddr_t'(i), regaddr_t'(NREGS - 1 - i));
         #1;
         chk($sformatf("reset_rd1[%0d]", i), bus.rd1, 64'h0);
         chk($sformatf("reset_rd2[%0d]", NREGS - 1 - i), bus.rd2, 64'h0);
      end
      next_cycle();

      // Table: drive after an edge, sample mid-cycle, then commit on the next edge.
      for (int v = 0; v < NVEC; v++) begin
         drive(vecs[v].regwrite, vecs[v].memtoreg, vecs[v].rd, vecs[v].readdata,
               vecs[v].alu, vecs[v].rs1, vecs[v].rs2);
         #3;
         chk($sformatf("v%0d_rd1", v), bus.rd1, vecs[v].exp_rd1);
         chk($sformatf("v%0d_rd2", v), bus.rd2, vecs[v].exp_rd2);
         chk($sformatf("v%0d_wb_data", v), bus.wb_data, vecs[v].exp_wb_data);
         chk($sformatf("v%0d_wb_en", v), 64'(bus.wb_en), 64'(vecs[v].exp_wb_en));
         chk($sformatf("v%0d_wr_count", v), bus.wr_count, vecs[v].exp_count);
         next_cycle();
      end

      // Async reset mid-cycle: write 0x55 to x3, then see storage cleared before the next edge.
      drive(1'b1, 1'b0, 5'd3, '0, 64'h55, 5'd0, 5'd0);
      next_cycle();
      drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd3, 5'd3);
      #1;
      chk("pre_reset_x3", bus.rd1, 64'h55);
      chk("pre_reset_count", bus.wr_count, 64'd6);
      reset = 1'b1;
      #1;
      chk("async_reset_rd1", bus.rd1, 64'h0);
      chk("async_reset_count", bus.wr_count, 64'd0);

      // Writes presented while reset is high must not land.
      drive(1'b1, 1'b0, 5'd3, '0, 64'h66, 5'd0, 5'd0);
      next_cycle();
      drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd3, 5'd5);
      reset = 1'b0;
      #1;
      chk("reset_held_x3", bus.rd1, 64'h0);
      chk("reset_held_x5", bus.rd2, 64'h0);
      chk("reset_held_count", bus.wr_count, 64'd0);

      // Counter wrap: preload all-ones in the low phase, then one effective write.
      @(negedge clk);
      dut.wr_count_q = '1;
      #1;
      chk("preload_count", bus.wr_count, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(1'b1, 1'b0, 5'd9, '0, 64'h9, 5'd0, 5'd0);
      next_cycle();
      drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd9, 5'd0);
      #1;
      chk("wrap_count", bus.wr_count, 64'd0);
      chk("wrap_x9", bus.rd1, 64'h9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
